// File: rtl/uart_rx_fast_stream_driver.sv
// Fast-link UART receiver: 8N1 bytes out as one-cycle outclk/out strobes,
// packet end signalled by a line-idle gap with the packet's byte count.
module uart_rx_fast_stream_driver #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned IDLE_CLKS    = 200,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rxd,
    output logic                   outclk,
    output logic [7:0]             out,
    output logic                   frame_err,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDLE_W  = $clog2(IDLE_CLKS + 1);

    localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] BIT_LOAD  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(IDLE_CLKS);
    localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(IDLE_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic                   r_sync1;
    logic                   r_rs;
    state_t                 r_state;
    logic [TIMER_W-1:0]     r_timer;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic [COUNT_WIDTH-1:0] r_byte_cnt;
    logic                   r_pkt;
    logic [IDLE_W-1:0]      r_idle_cnt;
    logic                   w_timer_zero;

    assign w_timer_zero = (r_timer == '0);

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rs    <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rs    <= r_sync1;
        end
    end

    // Frame FSM, byte counting and idle-gap packet termination.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_pkt      <= 1'b0;
            r_idle_cnt <= '0;
            outclk     <= 1'b0;
            out        <= '0;
            frame_err  <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
        end else begin
            outclk    <= 1'b0;
            frame_err <= 1'b0;
            done      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!r_rs) begin
                        r_timer <= HALF_LOAD;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (!w_timer_zero) begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end else if (r_rs) begin
                        // Start bit not low at its centre: treat as a glitch.
                        r_state <= S_IDLE;
                    end else begin
                        r_timer   <= BIT_LOAD;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!w_timer_zero) begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end else begin
                        r_shift   <= {r_rs, r_shift[7:1]};
                        r_timer   <= BIT_LOAD;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (!w_timer_zero) begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end else if (r_rs) begin
                        // Return to IDLE mid-stop-bit so back-to-back frames are caught.
                        out        <= r_shift;
                        outclk     <= 1'b1;
                        r_byte_cnt <= r_byte_cnt + COUNT_WIDTH'(1);
                        r_pkt      <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        r_state   <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (r_rs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Idle-gap counter; only counts in IDLE so it never overlaps a byte strobe.
            if (r_state == S_IDLE && r_rs) begin
                if (r_idle_cnt != IDLE_MAX) begin
                    r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                    if (r_idle_cnt == IDLE_LAST && r_pkt) begin
                        done       <= 1'b1;
                        count      <= r_byte_cnt;
                        r_byte_cnt <= '0;
                        r_pkt      <= 1'b0;
                    end
                end
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fast_stream_driver.sv
// Self-checking bench: drives 8N1 frames on rxd and scores strobes, frame
// errors and packet-end counts against a frame-level reference model.
module tb_uart_rx_fast_stream_driver;

    localparam int unsigned C    = 10;
    localparam int unsigned IDLE = 200;
    localparam int unsigned CW   = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rxd;
    logic          outclk;
    logic [7:0]    out;
    logic          frame_err;
    logic          done;
    logic [CW-1:0] count;

    uart_rx_fast_stream_driver #(
        .CLKS_PER_BIT (C),
        .IDLE_CLKS    (IDLE),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .outclk    (outclk),
        .out       (out),
        .frame_err (frame_err),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state: bytes owed, packet counts owed, frame errors owed.
    logic [7:0] exp_q[$];
    int         cnt_q[$];
    int         pkt_bytes = 0;
    int         exp_ferr = 0;
    int         exp_done_total = 0;
    int         exp_out_total = 0;

    int ferr_seen = 0;
    int n_out = 0;
    int n_done = 0;
    int last_out_cyc = 0;
    int last_done_cyc = 0;
    int start_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard sampled on the falling edge.
    always @(negedge clk) begin
        if (outclk) begin
            n_out++;
            last_out_cyc = cyc;
            if (exp_q.size() == 0) chk("outclk_unexpected", 32'(out), 32'hFFFF_FFFF);
            else                   chk("out_byte", 32'(out), 32'(exp_q.pop_front()));
        end
        if (frame_err) ferr_seen++;
        if (done) begin
            n_done++;
            last_done_cyc = cyc;
            if (cnt_q.size() == 0) chk("done_unexpected", 32'(count), 32'hFFFF_FFFF);
            else                   chk("done_count", 32'(count), 32'(cnt_q.pop_front()));
        end
        if (outclk && done) chk("outclk_with_done", 32'(1), 32'(0));
    end

    // Hold the line at v for n clock cycles (called on a falling edge).
    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame; stop_low > 0 drives a bad stop held low that many cycles.
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        start_cyc = cyc;
        hold(1'b0, C);
        for (int i = 0; i < 8; i++) hold(b[i], C);
        if (stop_low == 0) begin
            exp_q.push_back(b);
            exp_out_total++;
            pkt_bytes++;
            hold(1'b1, C);
        end else begin
            exp_ferr++;
            hold(1'b0, stop_low);
            hold(1'b1, C);
        end
    endtask

    // Idle line; gaps of 250+ cycles close any open packet.
    task automatic gap(input int n);
        if (n >= 250 && pkt_bytes > 0) begin
            cnt_q.push_back(pkt_bytes % (1 << CW));
            exp_done_total++;
            pkt_bytes = 0;
        end
        hold(1'b1, n);
    endtask

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [7:0] b2b [4];
        int lat;
        b2b[0] = 8'h55; b2b[1] = 8'h00; b2b[2] = 8'hFF; b2b[3] = 8'h3C;

        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("rst_outclk", 32'(outclk), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        rst = 1'b0;
        gap(300);
        chk("no_done_after_reset", n_done, 0);

        // Single byte: latency and done timing.
        send_frame(8'hA5, 0);
        gap(300);
        lat = last_out_cyc - start_cyc;
        chk("latency_in_window", 32'(lat >= 96 && lat <= 98), 1);
        chk("done_delay", last_done_cyc - last_out_cyc, IDLE);
        chk("single_outs", n_out, 1);
        chk("single_dones", n_done, 1);

        // Back-to-back frames at full line utilisation.
        for (int i = 0; i < 4; i++) send_frame(b2b[i], 0);
        gap(300);
        chk("b2b_ferr", ferr_seen, 0);
        chk("b2b_outs", n_out, 5);
        chk("b2b_dones", n_done, 2);

        // Short low glitch is rejected, following byte still received.
        hold(1'b0, 3);
        gap(40);
        chk("glitch_outs", n_out, 5);
        chk("glitch_ferr", ferr_seen, 0);
        send_frame(8'h12, 0);
        gap(300);
        chk("glitch_dones", n_done, 3);

        // Bad stop bit with a long break: one frame_err, count untouched.
        send_frame(8'h7E, 50);
        gap(30);
        chk("break_ferr", ferr_seen, 1);
        chk("break_outs", n_out, 6);
        send_frame(8'h81, 0);
        gap(300);
        chk("break_dones", n_done, 4);

        // Reset mid-frame discards the open packet and the frame in flight.
        send_frame(8'h5A, 0);
        gap(10);
        hold(1'b0, C * 5);
        hold(1'b1, C / 2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outclk", 32'(outclk), 0);
        chk("midrst_out", 32'(out), 0);
        chk("midrst_frame_err", 32'(frame_err), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_count", 32'(count), 0);
        rst = 1'b0;
        exp_q.delete();
        pkt_bytes = 0;
        gap(20);
        send_frame(8'h33, 0);
        gap(300);

        // Two packets of 2 and 3 random bytes, then random packets.
        for (int i = 0; i < 2; i++) send_frame(8'($urandom), 0);
        gap(250);
        for (int i = 0; i < 3; i++) send_frame(8'($urandom), 0);
        gap(250);
        for (int p = 0; p < 4; p++) begin
            int len;
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                send_frame(8'($urandom), 0);
                gap(int'($urandom_range(0, 25)));
            end
            gap(int'($urandom_range(250, 320)));
        end

        chk("end_bytes_pending", exp_q.size(), 0);
        chk("end_counts_pending", cnt_q.size(), 0);
        chk("end_ferr_total", ferr_seen, exp_ferr);
        chk("end_done_total", n_done, exp_done_total);
        chk("end_out_total", n_out, exp_out_total);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fast_stream_driver.md
Name: uart_rx_fast_stream_driver

Overview:
- Receive end of the fast UART link into the FPGA.
- Oversamples the serial input on a single fast clock (12 Mbaud at 120 MHz by default) and recovers 8N1 bytes.
- Emits each byte as a one-cycle outclk/out strobe, the same byte-stream convention stream_from_memory and the ethernet path consume.
- Marks packet boundaries by detecting an idle line gap after the last byte, and reports the packet's byte count.

Parameters:
- CLKS_PER_BIT, 10, clk cycles per UART bit (minimum 4).
- IDLE_CLKS, 200, cycles of continuous idle-high line after a received byte that end a packet.
- COUNT_WIDTH, 16, width of the byte counter.

Ports:
- clk  input  1  sole clock.
- rst  input  1  synchronous active-high reset.
- rxd  input  1  asynchronous UART line, idle high.
- outclk  output  1  one-cycle strobe; out is valid this cycle.
- out  output  8  received byte.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- done  output  1  one-cycle pulse at end of packet.
- count  output  COUNT_WIDTH  number of bytes in the packet just ended; valid while done=1, held afterwards.

Behaviour:
- Reset:
  - Synchronous, active-high, overrides everything including a byte in flight.
  - outclk, frame_err and done = 0; out = 0; count = 0.
  - Synchronizer flops = 1; state = IDLE; packet-active flag = 0; running byte counter = 0.
- Synchronizer: rxd passes through a 2-flop synchronizer; rs denotes the second flop. All logic uses rs only.
- States and transitions:
  - IDLE: when rs=0, load timer with CLKS_PER_BIT/2 - 1 (integer division) and go to START.
  - START: decrement the timer. At 0, sample rs.
    - rs=1: false start; go to IDLE. No output.
    - rs=0: reload timer with CLKS_PER_BIT-1, clear bit index, go to DATA.
  - DATA: at timer 0, shift rs into the byte LSB-first and reload the timer. After the 8th bit, go to STOP.
  - STOP: at timer 0, sample rs.
    - rs=1: out = byte, outclk=1 for exactly that cycle, byte counter += 1, packet flag = 1. Go to IDLE immediately, with no wait for the end of the stop bit, so back-to-back frames at 100% line utilisation are received.
    - rs=0: frame_err=1 for one cycle, no outclk, byte counter unchanged. Go to BREAK.
  - BREAK: wait until rs=1, then go to IDLE. A long break therefore yields exactly one frame_err.
- Idle gap and packet end:
  - The idle counter runs while state=IDLE and rs=1. It clears on any other cycle and saturates at IDLE_CLKS.
  - When the counter reaches IDLE_CLKS with the packet flag set:
    - done=1 for one cycle and count = byte counter.
    - Byte counter clears and packet flag clears.
  - With no bytes received, no done is ever produced, including after reset.
- Counter wrap: the byte counter wraps modulo 2^COUNT_WIDTH; no saturation and no error.
- Latency: outclk asserts 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after the falling edge of the start bit on rxd.
- out holds its value between strobes.
- outclk and done never assert in the same cycle, because done requires IDLE_CLKS ≥ 1 idle cycles after the strobe.
- Input jitter: at most ±CLKS_PER_BIT/2 - 1 cycles of cumulative bit-timing error over a frame is tolerated.

Test Plan:
- Single byte 0xA5 (CLKS_PER_BIT=10), then 300 idle cycles -> one outclk with out=0xA5, at 2+5+90 cycles ±1 after the start edge. done pulses once with count=1, exactly IDLE_CLKS cycles after rs returns high in IDLE.
- Back-to-back frames 0x55, 0x00, 0xFF, 0x3C with no inter-frame gap, then idle -> four outclk strobes with those values in order, no frame_err, one done with count=4.
- 3-cycle low glitch on an idle line -> no outclk, no frame_err, no done; a following valid byte 0x12 is received correctly.
- Frame 0x7E with stop bit driven 0, held low for 50 cycles, then high -> exactly one frame_err, no outclk, count unaffected. A subsequent byte 0x81 is received, and the next done reports count=1.
- Reset asserted for 1 cycle in the middle of bit 4 of a frame -> outputs are 0 the next cycle. The truncated frame produces no outclk; the remainder of that frame may be received as garbage. A clean 0x33 sent after 20 idle cycles is received correctly. No done reports bytes from before the reset.
- Two packets of 2 and 3 bytes separated by 250 idle cycles (IDLE_CLKS=200) -> done pulses twice, with count=2 and then count=3.
